// File: rtl/ins_analyser.sv
// Zero-latency MIPS-subset instruction-class decoder with a sticky illegal-instruction flag.
// Optional per-class retire counters are compiled in when INS_STATS_EN is defined.
module ins_analyser #(
  parameter logic [31:0] BUBBLE_IR = 32'hFFFF_FFFF,
  parameter int unsigned CNT_W     = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      IR,
  input  logic             valid,
  output logic             isLoad,
  output logic             isStore,
  output logic             isALUR,
  output logic             isALUImm,
  output logic             isBranch,
  output logic             isJump,
  output logic             isNop,
  output logic             isIllegal,
  output logic             illegal_seen
`ifdef INS_STATS_EN
  ,
  output logic [CNT_W-1:0] cnt_load,
  output logic [CNT_W-1:0] cnt_store,
  output logic [CNT_W-1:0] cnt_alur,
  output logic [CNT_W-1:0] cnt_aluimm,
  output logic [CNT_W-1:0] cnt_ctrl,
  output logic [CNT_W-1:0] cnt_nop
`endif
);

  logic [5:0] opcode;
  logic [5:0] funct;
  logic       raw_load;
  logic       raw_store;
  logic       raw_alur;
  logic       raw_aluimm;
  logic       raw_branch;
  logic       raw_jump;

  assign opcode = IR[31:26];
  assign funct  = IR[5:0];

  always_comb begin
    raw_load   = 1'b0;
    raw_store  = 1'b0;
    raw_alur   = 1'b0;
    raw_aluimm = 1'b0;
    raw_branch = 1'b0;
    raw_jump   = 1'b0;
    case (opcode)
      6'b000000: begin
        case (funct)
          6'b100000, 6'b100001, 6'b100010, 6'b100011,
          6'b100100, 6'b100101, 6'b100110, 6'b100111,
          6'b101010, 6'b101011,
          6'b000000, 6'b000010, 6'b000011,
          6'b000100, 6'b000110, 6'b000111: raw_alur = 1'b1;
          6'b001000:                       raw_jump = 1'b1;
          default: ;
        endcase
      end
      6'b001000, 6'b001001, 6'b001010, 6'b001011,
      6'b001100, 6'b001101, 6'b001110, 6'b001111: raw_aluimm = 1'b1;
      6'b100000, 6'b100001, 6'b100011,
      6'b100100, 6'b100101:                       raw_load   = 1'b1;
      6'b101000, 6'b101001, 6'b101011:            raw_store  = 1'b1;
      6'b000100, 6'b000101:                       raw_branch = 1'b1;
      6'b000010, 6'b000011:                       raw_jump   = 1'b1;
      default: ;
    endcase
  end

  // The all-zero word decodes as sll, so the full-word nop match must override every class.
  assign isNop     = (IR == 32'h0000_0000) || (IR == BUBBLE_IR);
  assign isLoad    = raw_load   & ~isNop;
  assign isStore   = raw_store  & ~isNop;
  assign isALUR    = raw_alur   & ~isNop;
  assign isALUImm  = raw_aluimm & ~isNop;
  assign isBranch  = raw_branch & ~isNop;
  assign isJump    = raw_jump   & ~isNop;
  assign isIllegal = ~(isNop | raw_load | raw_store | raw_alur | raw_aluimm | raw_branch | raw_jump);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      illegal_seen <= 1'b0;
    end else if (valid && isIllegal) begin
      illegal_seen <= 1'b1;
    end
  end

`ifdef INS_STATS_EN
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  // Counters wrap naturally at CNT_W bits; illegal words fall through every branch.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_load   <= '0;
      cnt_store  <= '0;
      cnt_alur   <= '0;
      cnt_aluimm <= '0;
      cnt_ctrl   <= '0;
      cnt_nop    <= '0;
    end else if (valid) begin
      if (isLoad)               cnt_load   <= cnt_load   + CNT_ONE;
      if (isStore)              cnt_store  <= cnt_store  + CNT_ONE;
      if (isALUR)               cnt_alur   <= cnt_alur   + CNT_ONE;
      if (isALUImm)             cnt_aluimm <= cnt_aluimm + CNT_ONE;
      if (isBranch || isJump)   cnt_ctrl   <= cnt_ctrl   + CNT_ONE;
      if (isNop)                cnt_nop    <= cnt_nop    + CNT_ONE;
    end
  end
`endif

endmodule

// File: tb/tb_ins_analyser.sv
// Directed-vector bench for ins_analyser with a list-based reference model and a per-cycle compare process.
module tb_ins_analyser;

  localparam int TB_CNT_W = 4;

  logic        clk;
  logic        rst;
  logic [31:0] IR;
  logic        valid;
  logic        isLoad, isStore, isALUR, isALUImm, isBranch, isJump, isNop, isIllegal;
  logic        illegal_seen;
`ifdef INS_STATS_EN
  logic [TB_CNT_W-1:0] cnt_load, cnt_store, cnt_alur, cnt_aluimm, cnt_ctrl, cnt_nop;
`endif

  int checks = 0;
  int errors = 0;

`ifdef INS_STATS_EN
  ins_analyser #(.BUBBLE_IR(32'hFFFF_FFFF), .CNT_W(TB_CNT_W)) dut (
    .clk(clk), .rst(rst), .IR(IR), .valid(valid),
    .isLoad(isLoad), .isStore(isStore), .isALUR(isALUR), .isALUImm(isALUImm),
    .isBranch(isBranch), .isJump(isJump), .isNop(isNop), .isIllegal(isIllegal),
    .illegal_seen(illegal_seen),
    .cnt_load(cnt_load), .cnt_store(cnt_store), .cnt_alur(cnt_alur),
    .cnt_aluimm(cnt_aluimm), .cnt_ctrl(cnt_ctrl), .cnt_nop(cnt_nop)
  );
`else
  ins_analyser #(.BUBBLE_IR(32'hFFFF_FFFF)) dut (
    .clk(clk), .rst(rst), .IR(IR), .valid(valid),
    .isLoad(isLoad), .isStore(isStore), .isALUR(isALUR), .isALUImm(isALUImm),
    .isBranch(isBranch), .isJump(isJump), .isNop(isNop), .isIllegal(isIllegal),
    .illegal_seen(illegal_seen)
  );
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: class membership from opcode/funct lists.
  // Flag vector order: {load, store, alur, aluimm, branch, jump, nop, illegal}.
  function automatic logic [7:0] model_flags(input logic [31:0] ir);
    logic [5:0] alur_f [16] = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27,
                                6'h2A, 6'h2B, 6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07};
    logic [5:0] imm_op  [8]  = '{6'h08, 6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h0E, 6'h0F};
    logic [5:0] load_op [5]  = '{6'h20, 6'h21, 6'h23, 6'h24, 6'h25};
    logic [5:0] store_op[3]  = '{6'h28, 6'h29, 6'h2B};
    logic [5:0] op, fn;
    op = ir[31:26];
    fn = ir[5:0];
    if (ir == 32'h0 || ir == 32'hFFFF_FFFF) return 8'h02;
    if (op == 6'h00) begin
      foreach (alur_f[i]) if (fn == alur_f[i]) return 8'h20;
      if (fn == 6'h08) return 8'h04;
      return 8'h01;
    end
    foreach (imm_op[i])   if (op == imm_op[i])   return 8'h10;
    foreach (load_op[i])  if (op == load_op[i])  return 8'h80;
    foreach (store_op[i]) if (op == store_op[i]) return 8'h40;
    if (op == 6'h04 || op == 6'h05) return 8'h08;
    if (op == 6'h02 || op == 6'h03) return 8'h04;
    return 8'h01;
  endfunction

  logic m_seen = 1'b0;
  int   m_cnt [6] = '{0, 0, 0, 0, 0, 0};  // load, store, alur, aluimm, ctrl, nop

  always @(posedge clk or posedge rst) begin
    logic [7:0] f;
    if (rst) begin
      m_seen <= 1'b0;
      for (int i = 0; i < 6; i++) m_cnt[i] <= 0;
    end else if (valid) begin
      f = model_flags(IR);
      if (f == 8'h01) m_seen <= 1'b1;
      if (f == 8'h80) m_cnt[0] <= (m_cnt[0] + 1) % (1 << TB_CNT_W);
      if (f == 8'h40) m_cnt[1] <= (m_cnt[1] + 1) % (1 << TB_CNT_W);
      if (f == 8'h20) m_cnt[2] <= (m_cnt[2] + 1) % (1 << TB_CNT_W);
      if (f == 8'h10) m_cnt[3] <= (m_cnt[3] + 1) % (1 << TB_CNT_W);
      if (f == 8'h08 || f == 8'h04) m_cnt[4] <= (m_cnt[4] + 1) % (1 << TB_CNT_W);
      if (f == 8'h02) m_cnt[5] <= (m_cnt[5] + 1) % (1 << TB_CNT_W);
    end
  end

  function automatic logic [7:0] dut_flags();
    return {isLoad, isStore, isALUR, isALUImm, isBranch, isJump, isNop, isIllegal};
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Per-cycle compare against the model, away from the rising edge.
  always @(negedge clk) begin
    chk("cyc_flags", {24'h0, dut_flags()}, {24'h0, model_flags(IR)});
    chk("cyc_illegal_seen", {31'h0, illegal_seen}, {31'h0, m_seen});
`ifdef INS_STATS_EN
    chk("cyc_cnt_load",   {28'h0, cnt_load},   32'(m_cnt[0]));
    chk("cyc_cnt_store",  {28'h0, cnt_store},  32'(m_cnt[1]));
    chk("cyc_cnt_alur",   {28'h0, cnt_alur},   32'(m_cnt[2]));
    chk("cyc_cnt_aluimm", {28'h0, cnt_aluimm}, 32'(m_cnt[3]));
    chk("cyc_cnt_ctrl",   {28'h0, cnt_ctrl},   32'(m_cnt[4]));
    chk("cyc_cnt_nop",    {28'h0, cnt_nop},    32'(m_cnt[5]));
`endif
  end

  typedef struct {
    logic [31:0] ir;
    logic [7:0]  flags;
  } vec_t;

  vec_t vecs [19] = '{
    '{32'h8C22_0004, 8'h80},  // lw
    '{32'hAC22_0004, 8'h40},  // sw
    '{32'h0022_1820, 8'h20},  // add
    '{32'h2022_0005, 8'h10},  // addi
    '{32'h3C01_1234, 8'h10},  // lui
    '{32'h0000_0000, 8'h02},  // nop
    '{32'hFFFF_FFFF, 8'h02},  // bubble
    '{32'h1022_0003, 8'h08},  // beq
    '{32'h03E0_0008, 8'h04},  // jr
    '{32'h0800_0010, 8'h04},  // j
    '{32'h0C00_0010, 8'h04},  // jal
    '{32'h0022_1843, 8'h20},  // sra
    '{32'h9422_0000, 8'h80},  // lhu
    '{32'hA422_0000, 8'h40},  // sh
    '{32'h1422_0003, 8'h08},  // bne
    '{32'h0022_1801, 8'h01},  // R-type, unknown funct
    '{32'h0420_0003, 8'h01},  // opcode 000001
    '{32'h8822_0000, 8'h01},  // opcode 100010
    '{32'hFC00_0001, 8'h01}   // opcode 111111
  };

  initial begin
    rst   = 1'b1;
    IR    = 32'hFFFF_FFFF;
    valid = 1'b0;
    #1;
    chk("reset_illegal_seen", {31'h0, illegal_seen}, 32'h0);
    chk("reset_bubble_flags", {24'h0, dut_flags()}, 32'h02);
    IR = 32'h8C22_0004;
    #1;
    chk("reset_comb_tracks", {24'h0, dut_flags()}, 32'h80);
    @(posedge clk); #2;
    rst = 1'b0;

    // Illegal words are presented with valid=0 so the sticky flag stays clear here.
    foreach (vecs[i]) begin
      @(posedge clk); #2;
      IR    = vecs[i].ir;
      valid = (vecs[i].flags != 8'h01);
      #1;
      chk($sformatf("vec%0d_%h", i, vecs[i].ir), {24'h0, dut_flags()}, {24'h0, vecs[i].flags});
      chk($sformatf("model%0d", i), {24'h0, model_flags(vecs[i].ir)}, {24'h0, vecs[i].flags});
    end
    @(posedge clk); #1;
    chk("seen_after_vectors", {31'h0, illegal_seen}, 32'h0);

    IR    = 32'hFC00_0001;
    valid = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
      chk("illegal_no_valid", {31'h0, illegal_seen}, 32'h0);
      chk("illegal_flag", {31'h0, isIllegal}, 32'h1);
    end
    valid = 1'b1;
    @(posedge clk); #1;
    chk("sticky_set", {31'h0, illegal_seen}, 32'h1);
    valid = 1'b0;
    IR    = 32'h8C22_0004;
    repeat (2) begin
      @(posedge clk); #1;
      chk("sticky_hold", {31'h0, illegal_seen}, 32'h1);
    end
    #3;
    rst = 1'b1;
    #1;
    chk("async_clear", {31'h0, illegal_seen}, 32'h0);
    chk("comb_during_rst", {31'h0, isLoad}, 32'h1);
    @(posedge clk); #2;
    rst = 1'b0;

`ifdef INS_STATS_EN
    IR    = 32'h8C22_0004;
    valid = 1'b1;
    repeat (17) @(posedge clk);
    #1;
    chk("cnt_load_wrap", {28'h0, cnt_load}, 32'h1);
    IR = 32'h0000_0000;
    repeat (2) @(posedge clk);
    #1;
    chk("cnt_nop_two", {28'h0, cnt_nop}, 32'h2);
    IR = 32'hFC00_0001;
    @(posedge clk); #1;
    chk("illegal_cnt_load", {28'h0, cnt_load}, 32'h1);
    chk("illegal_cnt_nop",  {28'h0, cnt_nop},  32'h2);
    chk("illegal_cnt_others", {16'h0, cnt_store, cnt_alur, cnt_aluimm, cnt_ctrl}, 32'h0);
    valid = 1'b0;
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    chk("cnt_async_clear", {8'h0, cnt_load, cnt_store, cnt_alur, cnt_aluimm, cnt_ctrl, cnt_nop}, 32'h0);
    @(posedge clk); #2;
    rst = 1'b0;
`endif

    repeat (2) @(posedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
